// File: rtl/bridge_pkg.sv
// Shared definitions for the processor-side IO bridge and its interval timers.
package bridge_pkg;

    // Timer FSM state encoding
    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_LOAD = 2'd1,
        T_CNT  = 2'd2,
        T_INT  = 2'd3
    } tstate_e;

    // CTRL register bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // Only MODE == 01 reloads; 00 and 1x are one-shot
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    // Word offsets inside a timer block
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    // CTRL fields, packed to match the bit positions above
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/bridge_timer.sv
// One interval timer: CTRL/PRESET/COUNT registers, count FSM and local read mux.
module bridge_timer
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    tstate_e     state, nstate;
    ctrl_t       ctrl, nctrl, wctrl;
    logic [31:0] preset, count, ncount;
    logic        ctrl_wr, preset_wr;

    assign ctrl_wr   = sel & we & (off == OFF_CTRL);
    assign preset_wr = sel & we & (off == OFF_PRESET);
    assign wctrl     = ctrl_t'(wdata[CTRL_IM:CTRL_EN]);

    // Next-state: CPU CTRL writes win over FSM-driven CTRL updates
    always_comb begin
        nstate = state;
        nctrl  = ctrl_wr ? wctrl : ctrl;
        ncount = count;
        case (state)
            // Looks at the value being written so the EN write edge itself enters LOAD
            T_IDLE: if (nctrl.en) nstate = T_LOAD;
            T_LOAD: begin
                ncount = preset;
                nstate = T_CNT;
            end
            T_CNT: begin
                if (count == 32'd0) begin
                    nstate = T_INT;
                    if (ctrl.mode != MODE_RELOAD && !ctrl_wr) nctrl.en = 1'b0;
                end else begin
                    ncount = count - 32'd1;
                end
            end
            T_INT: begin
                if (ctrl_wr) begin
                    nstate = wctrl.en ? T_LOAD : T_IDLE;
                end else if (ctrl.mode == MODE_RELOAD) begin
                    // Reload folded into the INT exit so the period is PRESET+2
                    ncount = preset;
                    nstate = T_CNT;
                end
            end
            default: nstate = T_IDLE;
        endcase
        // Disabling from software stops everything and freezes COUNT
        if (ctrl_wr && !wctrl.en) begin
            nstate = T_IDLE;
            ncount = count;
        end
    end

    // Register state, CTRL, PRESET, COUNT and the IRQ (high only while in INT)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= T_IDLE;
            ctrl   <= '0;
            preset <= '0;
            count  <= '0;
            irq    <= 1'b0;
        end else begin
            state  <= nstate;
            ctrl   <= nctrl;
            count  <= ncount;
            irq    <= (nstate == T_INT) & nctrl.im;
            if (preset_wr) preset <= wdata;
        end
    end

    // Local read mux; offset 3 and deselected reads return 0
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off)
                OFF_CTRL:   rdata = {28'd0, ctrl};
                OFF_PRESET: rdata = preset;
                OFF_COUNT:  rdata = count;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/io_bridge.sv
// CPU peripheral-bus bridge: decodes two timers and a device window, builds HWInt.
module io_bridge
    import bridge_pkg::*;
#(
    parameter logic [29:0] T0_BASE  = 30'h0000_1FC0,
    parameter logic [29:0] T1_BASE  = 30'h0000_1FC4,
    parameter logic [29:0] DEV_BASE = 30'h0000_1FC8
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] PrAddr,
    input  logic [31:0] PrWD,
    input  logic        IOWrite,
    output logic [31:0] PrRD,
    output logic [7:2]  HWInt,
    output logic [2:0]  DevAddr,
    output logic [31:0] DevWD,
    output logic        DevWe,
    input  logic [31:0] DevRD,
    input  logic        DevIrq
);

    localparam int NUM_TIMERS = 2;
    localparam logic [NUM_TIMERS-1:0][29:0] TBASE = {T1_BASE, T0_BASE};

    logic [NUM_TIMERS-1:0]       t_sel, t_irq;
    logic [NUM_TIMERS-1:0][31:0] t_rdata;
    logic                        dev_hit;

    genvar i;
    generate
        for (i = 0; i < NUM_TIMERS; i++) begin : g_tmr
            assign t_sel[i] = (PrAddr[29:2] == TBASE[i][29:2]);
            bridge_timer u_tmr (
                .clk   (clk),
                .rst   (rst),
                .sel   (t_sel[i]),
                .we    (IOWrite),
                .off   (PrAddr[1:0]),
                .wdata (PrWD),
                .rdata (t_rdata[i]),
                .irq   (t_irq[i])
            );
        end
    endgenerate

    assign dev_hit = (PrAddr[29:3] == DEV_BASE[29:3]);
    assign DevAddr = PrAddr[2:0];
    assign DevWD   = PrWD;
    assign DevWe   = IOWrite & dev_hit & ~rst;

    // Read-back mux; anything unmapped reads 0
    always_comb begin
        PrRD = '0;
        for (int k = 0; k < NUM_TIMERS; k++)
            if (t_sel[k]) PrRD = t_rdata[k];
        if (dev_hit) PrRD = DevRD;
    end

    assign HWInt = {3'b000, DevIrq & ~rst, t_irq[1], t_irq[0]};

endmodule
